neuron_wta_sched: RTL and testbench

- Event scheduler and winner-take-all controller for a layer of P_NEURONS 8-input neurons that share one event bus.
- Accepts one input event at a time (valid/ready). Drives the one-hot event line to all neurons and waits for the synapse/adder path to settle.
- Serially scans the neuron outputs, picks the single largest above-threshold value, and issues a one-cycle spike to the winning neuron only. This latches that neuron's level value.
- Sits between the input event source and the neuron array.

---
 rtl/neuron_wta_sched_if.sv | 30 +++
 rtl/neuron_wta_sched.sv | 151 +++++++++++++++
 tb/tb_neuron_wta_sched.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/neuron_wta_sched_if.sv
// Event-bus / neuron-array bundle for the winner-take-all scheduler.
// master = event source + neuron array side, slave = scheduler.
interface neuron_wta_sched_if #(
  parameter int P_NEURONS   = 4,
  parameter int P_VAL_WIDTH = 21
);
  logic                             i_ev_valid;
  logic [2:0]                       i_ev_addr;
  logic                             o_ev_ready;
  logic [7:0]                       o_event;
  logic [P_NEURONS*P_VAL_WIDTH-1:0] i_neuron_out;
  logic [P_NEURONS-1:0]             o_spike;
  logic                             o_win_valid;
  logic                             o_win_hit;
  logic [3:0]                       o_win_idx;
  logic [P_VAL_WIDTH-1:0]           o_win_value;
  logic                             o_busy;

  modport master (
    output i_ev_valid, i_ev_addr, i_neuron_out,
    input  o_ev_ready, o_event, o_spike, o_win_valid, o_win_hit,
           o_win_idx, o_win_value, o_busy
  );

  modport slave (
    input  i_ev_valid, i_ev_addr, i_neuron_out,
    output o_ev_ready, o_event, o_spike, o_win_valid, o_win_hit,
           o_win_idx, o_win_value, o_busy
  );
endinterface

// File: rtl/neuron_wta_sched.sv
// Event scheduler + serial winner-take-all scan over a shared-bus neuron layer.
// Latency: report P_SETTLE+P_NEURONS+2 cycles after accept; ready (no queueing) only in IDLE.
module neuron_wta_sched #(
  parameter int P_NEURONS   = 4,
  parameter int P_VAL_WIDTH = 21,
  parameter int P_SETTLE    = 2
) (
  input logic              i_clk,
  input logic              i_rst_n,
  neuron_wta_sched_if.slave bus
);
  localparam int IDX_W = 4;
  localparam int CNT_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(P_NEURONS - 1);
  localparam logic [CNT_W-1:0] LAST_SETTLE = CNT_W'(P_SETTLE - 1);

  typedef enum logic [2:0] {IDLE, FIRE, SETTLE, SCAN, REPORT} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       settle_cnt, settle_nxt;
  logic [IDX_W-1:0]       scan_idx, scan_nxt;
  logic [P_VAL_WIDTH-1:0] best_val, best_val_nxt;
  logic [IDX_W-1:0]       best_idx, best_idx_nxt;
  logic [7:0]             event_q, event_nxt;
  logic [P_NEURONS-1:0]   spike_q, spike_nxt;
  logic                   win_valid_q, win_valid_nxt;
  logic                   win_hit_q, win_hit_nxt;
  logic [IDX_W-1:0]       win_idx_q, win_idx_nxt;
  logic [P_VAL_WIDTH-1:0] win_value_q, win_value_nxt;

  logic [P_VAL_WIDTH-1:0] sample;
  logic [P_VAL_WIDTH-1:0] cand_val;
  logic [IDX_W-1:0]       cand_idx;
  logic                   cand_hit;

  // Neuron output mux; only the slot addressed by scan_idx is looked at.
  always_comb begin
    sample = '0;
    for (int n = 0; n < P_NEURONS; n++) begin
      if (scan_idx == n[IDX_W-1:0]) begin
        sample = bus.i_neuron_out[n*P_VAL_WIDTH +: P_VAL_WIDTH];
      end
    end
  end

  // Strict compare: ties keep the earlier (lower) index, and a zero output never beats the cleared best.
  always_comb begin
    cand_val = best_val;
    cand_idx = best_idx;
    if (sample > best_val) begin
      cand_val = sample;
      cand_idx = scan_idx;
    end
    cand_hit = (cand_val != '0);
  end

  always_comb begin
    state_nxt     = state;
    settle_nxt    = settle_cnt;
    scan_nxt      = scan_idx;
    best_val_nxt  = best_val;
    best_idx_nxt  = best_idx;
    event_nxt     = '0;
    spike_nxt     = '0;
    win_valid_nxt = 1'b0;
    win_hit_nxt   = win_hit_q;
    win_idx_nxt   = win_idx_q;
    win_value_nxt = win_value_q;

    case (state)
      IDLE: begin
        if (bus.i_ev_valid) begin
          event_nxt = 8'b1 << bus.i_ev_addr;
          state_nxt = FIRE;
        end
      end
      FIRE: begin
        best_val_nxt = '0;
        best_idx_nxt = '0;
        settle_nxt   = '0;
        state_nxt    = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == LAST_SETTLE) begin
          scan_nxt  = '0;
          state_nxt = SCAN;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      SCAN: begin
        best_val_nxt = cand_val;
        best_idx_nxt = cand_idx;
        if (scan_idx == LAST_IDX) begin
          // Result registers load on the last scan edge so they are visible during REPORT.
          win_valid_nxt = 1'b1;
          win_hit_nxt   = cand_hit;
          win_idx_nxt   = cand_idx;
          win_value_nxt = cand_val;
          spike_nxt     = cand_hit ? (P_NEURONS'(1) << cand_idx) : '0;
          state_nxt     = REPORT;
        end else begin
          scan_nxt = scan_idx + 1'b1;
        end
      end
      REPORT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      scan_idx    <= '0;
      best_val    <= '0;
      best_idx    <= '0;
      event_q     <= '0;
      spike_q     <= '0;
      win_valid_q <= 1'b0;
      win_hit_q   <= 1'b0;
      win_idx_q   <= '0;
      win_value_q <= '0;
    end else begin
      state       <= state_nxt;
      settle_cnt  <= settle_nxt;
      scan_idx    <= scan_nxt;
      best_val    <= best_val_nxt;
      best_idx    <= best_idx_nxt;
      event_q     <= event_nxt;
      spike_q     <= spike_nxt;
      win_valid_q <= win_valid_nxt;
      win_hit_q   <= win_hit_nxt;
      win_idx_q   <= win_idx_nxt;
      win_value_q <= win_value_nxt;
    end
  end

  assign bus.o_ev_ready  = (state == IDLE);
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_event     = event_q;
  assign bus.o_spike     = spike_q;
  assign bus.o_win_valid = win_valid_q;
  assign bus.o_win_hit   = win_hit_q;
  assign bus.o_win_idx   = win_idx_q;
  assign bus.o_win_value = win_value_q;
endmodule

// File: tb/tb_neuron_wta_sched.sv
// Directed bench for neuron_wta_sched: reset, winner selection, ties, no-hit, back-to-back, mid-scan reset.
module tb_neuron_wta_sched;
  localparam int N = 4;
  localparam int W = 21;
  localparam int S = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_wta_sched_if #(.P_NEURONS(N), .P_VAL_WIDTH(W)) bus ();

  neuron_wta_sched #(.P_NEURONS(N), .P_VAL_WIDTH(W), .P_SETTLE(S)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vals(input int v0, input int v1, input int v2, input int v3);
    bus.i_neuron_out = {W'(v3), W'(v2), W'(v1), W'(v0)};
  endtask

  // Caller is in an IDLE cycle; this cycle becomes cycle 0 (handshake).
  task automatic run_event(input string tag, input logic [2:0] addr, input int exp_event,
                           input int exp_hit, input int exp_idx, input int exp_val,
                           input int exp_spike);
    int noise;
    chk({tag, "_ready0"}, 32'(bus.o_ev_ready), 32'd1);
    bus.i_ev_valid = 1'b1;
    bus.i_ev_addr  = addr;
    tick;
    bus.i_ev_valid = 1'b0;
    chk({tag, "_event_c1"}, 32'(bus.o_event), 32'(exp_event));
    noise = 0;
    for (int c = 2; c <= 7; c++) begin
      tick;
      if (bus.o_event != 8'h00 || bus.o_win_valid || bus.o_spike != '0 || bus.o_ev_ready)
        noise++;
    end
    chk({tag, "_quiet_c2_7"}, 32'(noise), 32'd0);
    tick;
    chk({tag, "_valid_c8"}, 32'(bus.o_win_valid), 32'd1);
    chk({tag, "_hit"},      32'(bus.o_win_hit),   32'(exp_hit));
    chk({tag, "_idx"},      32'(bus.o_win_idx),   32'(exp_idx));
    chk({tag, "_value"},    32'(bus.o_win_value), 32'(exp_val));
    chk({tag, "_spike"},    32'(bus.o_spike),     32'(exp_spike));
    tick;
    chk({tag, "_ready_c9"}, 32'(bus.o_ev_ready),  32'd1);
    chk({tag, "_pulse_off"}, 32'({bus.o_win_valid, bus.o_spike}), 32'd0);
    chk({tag, "_value_hold"}, 32'(bus.o_win_value), 32'(exp_val));
  endtask

  initial begin
    int noise;
    int ev_count;
    bus.i_ev_valid   = 1'b0;
    bus.i_ev_addr    = 3'd0;
    bus.i_neuron_out = '0;
    #12;
    chk("rst_ready",     32'(bus.o_ev_ready),  32'd1);
    chk("rst_busy",      32'(bus.o_busy),      32'd0);
    chk("rst_event",     32'(bus.o_event),     32'd0);
    chk("rst_spike",     32'(bus.o_spike),     32'd0);
    chk("rst_win_valid", 32'(bus.o_win_valid), 32'd0);
    chk("rst_win_hit",   32'(bus.o_win_hit),   32'd0);
    chk("rst_win_idx",   32'(bus.o_win_idx),   32'd0);
    chk("rst_win_value", 32'(bus.o_win_value), 32'd0);
    tick;
    rst_n = 1'b1;

    noise = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (bus.o_busy || bus.o_event != 8'h00 || bus.o_win_valid || !bus.o_ev_ready) noise++;
    end
    chk("idle_20", 32'(noise), 32'd0);

    set_vals(0, 500, 120, 0);
    run_event("single", 3'd3, 32'h08, 1, 1, 500, 4'b0010);

    set_vals(0, 300, 300, 300);
    run_event("tie", 3'd5, 32'h20, 1, 1, 300, 4'b0010);

    set_vals(0, 0, 0, 0);
    run_event("none", 3'd0, 32'h01, 0, 0, 0, 4'b0000);

    set_vals(10, 20, 30, 40);
    run_event("last", 3'd6, 32'h40, 1, 3, 40, 4'b1000);

    set_vals(7, 0, 0, 0);
    run_event("first", 3'd1, 32'h02, 1, 0, 7, 4'b0001);

    // Back-to-back: request held high, addr 0 then 7.
    set_vals(0, 0, 9, 0);
    bus.i_ev_valid = 1'b1;
    bus.i_ev_addr  = 3'd0;
    tick;
    chk("b2b_event_a", 32'(bus.o_event), 32'h01);
    bus.i_ev_addr = 3'd7;
    ev_count = 0;
    for (int c = 2; c <= 18; c++) begin
      tick;
      if (bus.o_event != 8'h00) ev_count++;
      if (c == 10) begin
        chk("b2b_event_b", 32'(bus.o_event), 32'h80);
        bus.i_ev_valid = 1'b0;
      end
    end
    chk("b2b_event_count", 32'(ev_count), 32'd1);

    // Reset in cycle 5 (scan slot 1).
    set_vals(0, 77, 0, 0);
    bus.i_ev_valid = 1'b1;
    bus.i_ev_addr  = 3'd2;
    tick;
    bus.i_ev_valid = 1'b0;
    for (int c = 2; c <= 5; c++) tick;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",  32'(bus.o_busy),     32'd0);
    chk("midrst_ready", 32'(bus.o_ev_ready), 32'd1);
    tick;
    tick;
    rst_n = 1'b1;
    noise = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (bus.o_win_valid || bus.o_spike != '0 || bus.o_busy) noise++;
    end
    chk("midrst_no_pulse", 32'(noise), 32'd0);

    set_vals(0, 0, 250, 90);
    run_event("post_rst", 3'd4, 32'h10, 1, 2, 250, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
